// File: rtl/conv_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_sweep_ctrl
// Purpose  : Drives a 4-input code converter (w,x,y,z -> y3..y0) through the
//            codes 0..LAST. Each code is held for DWELL cycles. The converter
//            response is sampled on the last cycle of each dwell and compared
//            against the EXPECT lookup table.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            start, abort           - sweep control (start is level-sampled)
//            w, x, y, z             - converter inputs (w is the MSB)
//            y3, y2, y1, y0         - converter outputs (y3 is the MSB)
//            code_out, result       - code and sampled response of the step
//            step_valid, mismatch   - per-step strobe and compare flag
//            err_count              - saturating mismatch count for the sweep
//            busy, done             - sweep in progress / normal completion
// Revision : 1.0 - initial release
// ============================================================================
module conv_sweep_ctrl #(
    parameter int          DWELL  = 5,
    parameter int          LAST   = 15,
    parameter logic [63:0] EXPECT = 64'h210FEDCBA9876543
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       w,
    output logic       x,
    output logic       y,
    output logic       z,
    input  logic       y3,
    input  logic       y2,
    input  logic       y1,
    input  logic       y0,
    output logic [3:0] code_out,
    output logic [3:0] result,
    output logic       step_valid,
    output logic       mismatch,
    output logic [4:0] err_count,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] c_DWELL_M1 = 8'(DWELL - 1);
    localparam logic [3:0] c_LAST     = 4'(LAST);
    localparam logic [4:0] c_ERR_MAX  = 5'd31;

    state_t     r_state;
    logic [3:0] r_code;   // code currently under test
    logic [3:0] r_drive;  // registered value presented on w,x,y,z
    logic [7:0] r_cnt;    // dwell counter

    logic [3:0] w_sample;
    logic [3:0] w_expect;
    logic       w_sample_edge;
    logic       w_mis;

    assign w_sample      = {y3, y2, y1, y0};
    assign w_expect      = EXPECT[{r_code, 2'b00} +: 4];
    assign w_sample_edge = (r_cnt == c_DWELL_M1);
    assign w_mis         = (w_sample != w_expect);

    assign {w, x, y, z}  = r_drive;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_code     <= 4'd0;
            r_drive    <= 4'd0;
            r_cnt      <= 8'd0;
            code_out   <= 4'd0;
            result     <= 4'd0;
            step_valid <= 1'b0;
            mismatch   <= 1'b0;
            err_count  <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Strobes default low; they are raised for exactly one cycle.
            step_valid <= 1'b0;
            mismatch   <= 1'b0;
            done       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_drive <= 4'd0;
                    busy    <= 1'b0;
                    if (start && !abort) begin
                        r_state   <= ST_DRIVE;
                        r_code    <= 4'd0;
                        r_cnt     <= 8'd0;
                        err_count <= 5'd0;
                        busy      <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (abort) begin
                        // Abort beats a coincident sample: no strobe, no count.
                        r_state <= ST_IDLE;
                        r_drive <= 4'd0;
                        busy    <= 1'b0;
                    end else if (w_sample_edge) begin
                        result     <= w_sample;
                        code_out   <= r_code;
                        step_valid <= 1'b1;
                        mismatch   <= w_mis;
                        if (w_mis && (err_count != c_ERR_MAX)) begin
                            err_count <= err_count + 5'd1;
                        end
                        if (r_code == c_LAST) begin
                            r_state <= ST_DONE;
                            r_drive <= 4'd0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_code  <= r_code + 4'd1;
                            r_drive <= r_code + 4'd1;
                            r_cnt   <= 8'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_drive <= 4'd0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
